// File: rtl/shift_register_pkg.sv
// Shared constants for the serial-in/parallel-out shift register.
package shift_register_pkg;
    localparam int SHIFT_REGISTER_DEFAULT_WIDTH = 8;
endpackage

// File: rtl/shift_register_stage.sv
// One storage cell of the shift chain: enable-gated flop with async active-low clear.
module shift_register_stage (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            q <= 1'b0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/shift_register.sv
// Serial-in, parallel-out shift register; bit 0 holds the newest bit.
// Define SHIFT_REGISTER_SEROUT_EN to add a registered serial_out of the bit shifted out.
module shift_register
    import shift_register_pkg::*;
#(
    parameter int WIDTH = SHIFT_REGISTER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             data_in,
    input  logic             shift_enable,
`ifdef SHIFT_REGISTER_SEROUT_EN
    output logic             serial_out,
`endif
    output logic [WIDTH-1:0] data_out
);
    // Next value of every stage when shifting: neighbour below, data_in at the LSB.
    logic [WIDTH-1:0] stage_d;
    assign stage_d = {data_out[WIDTH-2:0], data_in};

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        shift_register_stage u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (shift_enable),
            .d       (stage_d[i]),
            .q       (data_out[i])
        );
    end

`ifdef SHIFT_REGISTER_SEROUT_EN
    // Captures the outgoing MSB on the same edge that drops it from data_out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            serial_out <= 1'b0;
        else if (shift_enable)
            serial_out <= data_out[WIDTH-1];
    end
`endif
endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench: directed vector table, corner sequences, randomized run vs. arithmetic model.
module tb_shift_register;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        data_in;
    logic        shift_enable;
    logic [7:0]  data_out;
    logic [15:0] data_out16;
`ifdef SHIFT_REGISTER_SEROUT_EN
    logic        serial_out;
    logic        serial_out16;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_register #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .shift_enable (shift_enable),
`ifdef SHIFT_REGISTER_SEROUT_EN
        .serial_out   (serial_out),
`endif
        .data_out     (data_out)
    );

    shift_register #(.WIDTH(16)) dut16 (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .shift_enable (shift_enable),
`ifdef SHIFT_REGISTER_SEROUT_EN
        .serial_out   (serial_out16),
`endif
        .data_out     (data_out16)
    );

    typedef struct {
        bit         rst_n;
        bit         en;
        bit         din;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int m8;
        int m16;
        int so8;
        int so16;

        vecs[0] = '{1'b0, 1'b1, 1'b1, 8'h00};  // reset low dominates enable
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 8'h01};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h03};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 8'h06};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 8'h0D};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 8'h0D};

        reset_n      = 1'b0;
        data_in      = 1'b0;
        shift_enable = 1'b0;
        #2;
        check("reset_async", longint'(data_out), 0);
        tick();

        for (int i = 0; i < 8; i++) begin
            reset_n      = vecs[i].rst_n;
            shift_enable = vecs[i].en;
            data_in      = vecs[i].din;
            tick();
            check($sformatf("vec%0d", i), longint'(data_out), longint'(vecs[i].exp));
        end

        // Hold with an undriven/unknown data_in must not disturb contents.
        shift_enable = 1'b0;
        data_in      = 1'bx;
        tick();
        check("hold_x", longint'(data_out), 64'h0D);

        // Async clear between edges.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_clear", longint'(data_out), 0);
        check("async_clear16", longint'(data_out16), 0);
        tick();
        reset_n = 1'b1;

        // Eight ones then a zero: MSB drops off.
        shift_enable = 1'b1;
        data_in      = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("fill_ones", longint'(data_out), 64'hFF);
        data_in = 1'b0;
        tick();
        check("drop_msb", longint'(data_out), 64'hFE);
`ifdef SHIFT_REGISTER_SEROUT_EN
        check("serial_out_msb", longint'(serial_out), 1);
`endif

        // Reset mid-shift, then first shift after release.
        data_in = 1'b1;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("midshift_clear", longint'(data_out), 0);
`ifdef SHIFT_REGISTER_SEROUT_EN
        check("serial_out_clear", longint'(serial_out), 0);
`endif
        tick();
        reset_n = 1'b1;
        data_in = 1'b1;
        tick();
        check("first_after_rst", longint'(data_out), 64'h01);

        // 16-bit instance: alternating bits starting with 1.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_in = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
        end
        check("alt16", longint'(data_out16), 64'hAAAA);

        // Randomized run against an arithmetic model of both widths.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        m8 = 0; m16 = 0; so8 = 0; so16 = 0;
        for (int i = 0; i < 300; i++) begin
            shift_enable = 1'($urandom);
            data_in      = 1'($urandom);
            tick();
            if (shift_enable) begin
                so8  = m8 / 128;
                so16 = m16 / 32768;
                m8   = (m8 * 2 + int'(data_in)) % 256;
                m16  = (m16 * 2 + int'(data_in)) % 65536;
            end
            check("rand8", longint'(data_out), longint'(m8));
            check("rand16", longint'(data_out16), longint'(m16));
`ifdef SHIFT_REGISTER_SEROUT_EN
            check("rand_so8", longint'(serial_out), longint'(so8));
            check("rand_so16", longint'(serial_out16), longint'(so16));
`endif
            if ($urandom_range(0, 19) == 0) begin
                #2;
                reset_n = 1'b0;
                #1;
                check("rand_rst8", longint'(data_out), 0);
                check("rand_rst16", longint'(data_out16), 0);
                m8 = 0; m16 = 0; so8 = 0; so16 = 0;
                reset_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
